// File: rtl/gray_codec_pkg.sv
// Shared constants and helpers for the Gray codec pipeline.
// Optional step checking is enabled with the GRAY_STEP_CHECK_EN macro.
package gray_codec_pkg;

  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;
  localparam int   MAX_W    = 64;

  // Gray->binary bits each stage resolves, MSB-first.
  function automatic int bits_per_stage(input int data_w, input int pipe_stages);
    return (data_w + pipe_stages - 1) / pipe_stages;
  endfunction

  // True when two Gray words differ in more than one bit position.
  function automatic logic gray_multi_step(input logic [MAX_W-1:0] a,
                                           input logic [MAX_W-1:0] b);
    logic [MAX_W-1:0] x;
    x = a ^ b;
    return (x & (x - 64'd1)) != '0;
  endfunction

endpackage

// File: rtl/gray_codec_stage.sv
// One elastic register stage of the Gray codec pipeline with its slice of the
// Gray->binary prefix XOR; stage 0 also does the full binary->Gray encode.
module gray_codec_stage
  import gray_codec_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int STAGE_IDX = 0,
  parameter int BPS       = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              up_vld,
  output logic              up_rdy,
  input  logic              up_mode,
  input  logic [DATA_W-1:0] up_data,
`ifdef GRAY_STEP_CHECK_EN
  input  logic              up_err,
  output logic              dn_err,
`endif
  output logic              dn_vld,
  input  logic              dn_rdy,
  output logic              dn_mode,
  output logic [DATA_W-1:0] dn_data
);

  // Bit window [HI:LO] resolved here; LO may go negative on the last stage.
  localparam int HI = DATA_W - 1 - STAGE_IDX * BPS;
  localparam int LO = DATA_W - (STAGE_IDX + 1) * BPS;

  logic              vld_q;
  logic              mode_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] nxt;
  logic              carry;
  logic              load;

  assign up_rdy = !vld_q || dn_rdy;
  assign load   = up_vld && up_rdy;

  // Bits above HI arrive already binary, so carry picks up b[HI+1] on its way down.
  always_comb begin
    nxt   = up_data;
    carry = 1'b0;
    if (up_mode == MODE_G2B) begin
      for (int i = DATA_W - 1; i >= 0; i--) begin
        if (i <= HI && i >= LO) nxt[i] = carry ^ up_data[i];
        carry = nxt[i];
      end
    end else if (STAGE_IDX == 0) begin
      nxt = up_data ^ (up_data >> 1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_q  <= 1'b0;
      mode_q <= 1'b0;
      data_q <= '0;
    end else begin
      if (up_rdy) vld_q <= up_vld;
      if (load) begin
        mode_q <= up_mode;
        data_q <= nxt;
      end
    end
  end

`ifdef GRAY_STEP_CHECK_EN
  logic err_q;
  always_ff @(posedge i_clk) begin
    if (i_rst)     err_q <= 1'b0;
    else if (load) err_q <= up_err;
  end
  assign dn_err = err_q;
`endif

  assign dn_vld  = vld_q;
  assign dn_mode = mode_q;
  assign dn_data = data_q;

endmodule

// File: rtl/gray_codec_pipe.sv
// Elastic binary<->Gray converter, PIPE_STAGES deep with valid/ready flow control.
// Define GRAY_STEP_CHECK_EN to add o_step_err (multi-bit Gray step detection).
module gray_codec_pipe
  import gray_codec_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int PIPE_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_vld,
  output logic              o_rdy,
  input  logic              i_mode,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_vld,
  input  logic              i_rdy,
  output logic              o_mode,
`ifdef GRAY_STEP_CHECK_EN
  output logic              o_step_err,
`endif
  output logic [DATA_W-1:0] o_data
);

  localparam int BPS = bits_per_stage(DATA_W, PIPE_STAGES);

  // Index s is the input of stage s; index PIPE_STAGES is the block output.
  logic [PIPE_STAGES:0]             vld_pipe;
  logic [PIPE_STAGES:0]             rdy_pipe;
  logic [PIPE_STAGES:0]             mode_pipe;
  logic [PIPE_STAGES:0][DATA_W-1:0] dat_pipe;

  assign vld_pipe[0]           = i_vld;
  assign mode_pipe[0]          = i_mode;
  assign dat_pipe[0]           = i_data;
  assign rdy_pipe[PIPE_STAGES] = i_rdy;
  assign o_rdy                 = rdy_pipe[0];

`ifdef GRAY_STEP_CHECK_EN
  logic [PIPE_STAGES:0] err_pipe;
  logic [DATA_W-1:0]    ref_q;
  logic                 ref_vld_q;

  // Compare against the last accepted Gray->binary word; none exists after reset.
  assign err_pipe[0] = (i_mode == MODE_G2B) && ref_vld_q &&
                       gray_multi_step(MAX_W'(ref_q), MAX_W'(i_data));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ref_q     <= '0;
      ref_vld_q <= 1'b0;
    end else if (i_vld && o_rdy && i_mode == MODE_G2B) begin
      ref_q     <= i_data;
      ref_vld_q <= 1'b1;
    end
  end

  assign o_step_err = err_pipe[PIPE_STAGES];
`endif

  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    gray_codec_stage #(
      .DATA_W    (DATA_W),
      .STAGE_IDX (s),
      .BPS       (BPS)
    ) u_stage (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .up_vld  (vld_pipe[s]),
      .up_rdy  (rdy_pipe[s]),
      .up_mode (mode_pipe[s]),
      .up_data (dat_pipe[s]),
`ifdef GRAY_STEP_CHECK_EN
      .up_err  (err_pipe[s]),
      .dn_err  (err_pipe[s+1]),
`endif
      .dn_vld  (vld_pipe[s+1]),
      .dn_rdy  (rdy_pipe[s+1]),
      .dn_mode (mode_pipe[s+1]),
      .dn_data (dat_pipe[s+1])
    );
  end

  assign o_vld  = vld_pipe[PIPE_STAGES];
  assign o_mode = mode_pipe[PIPE_STAGES];
  assign o_data = dat_pipe[PIPE_STAGES];

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Self-checking bench for gray_codec_pipe: 8-bit/2-stage and 13-bit/3-stage instances.
module tb_gray_codec_pipe;

  logic clk;
  logic rst;
  logic i_vld, i_mode, i_rdy;
  logic [7:0] i_data;
  logic o_rdy, o_vld, o_mode;
  logic [7:0] o_data;
  logic v13, m13, r13;
  logic [12:0] d13;
  logic o13_rdy, o13_vld, o13_mode;
  logic [12:0] o13_data;
`ifdef GRAY_STEP_CHECK_EN
  logic o_step_err, o13_step_err;
`endif

  gray_codec_pipe #(.DATA_W(8), .PIPE_STAGES(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_vld(i_vld), .o_rdy(o_rdy), .i_mode(i_mode),
    .i_data(i_data), .o_vld(o_vld), .i_rdy(i_rdy), .o_mode(o_mode),
`ifdef GRAY_STEP_CHECK_EN
    .o_step_err(o_step_err),
`endif
    .o_data(o_data));

  gray_codec_pipe #(.DATA_W(13), .PIPE_STAGES(3)) u_w13 (
    .i_clk(clk), .i_rst(rst), .i_vld(v13), .o_rdy(o13_rdy), .i_mode(m13),
    .i_data(d13), .o_vld(o13_vld), .i_rdy(r13), .o_mode(o13_mode),
`ifdef GRAY_STEP_CHECK_EN
    .o_step_err(o13_step_err),
`endif
    .o_data(o13_data));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       mode;
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t        q[$];
  logic [12:0] q13[$];
  logic [12:0] cap13[$];
  logic [12:0] rt_src[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        s_vld, s_rdy, s_mode, s_err;
  logic [7:0]  s_data;
  logic        hold_pending = 1'b0;
  logic [7:0]  ref_g = 8'h00;
  logic        ref_ok = 1'b0;

  // Gray->binary by doubling prefix XOR; binary->Gray by shift-XOR.
  function automatic logic [63:0] g2b(input logic [63:0] g, input int w);
    logic [63:0] r;
    r = g;
    for (int s = 1; s < w; s = s * 2) r = r ^ (r >> s);
    return r;
  endfunction

  function automatic logic [63:0] b2g(input logic [63:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle on the 8-bit instance: drive, sample at negedge, score, advance.
  task automatic step8(input logic v, input logic m, input logic [7:0] d, input logic r);
    exp_t e;
    i_vld = v; i_mode = m; i_data = d; i_rdy = r;
    @(negedge clk);
    s_vld = o_vld; s_rdy = o_rdy; s_mode = o_mode; s_data = o_data;
`ifdef GRAY_STEP_CHECK_EN
    s_err = o_step_err;
`else
    s_err = 1'b0;
`endif
    if (hold_pending) chk("hold_vld", 64'(o_vld), 64'd1);
    if (o_vld === 1'b1) begin
      chk("spurious_out", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        chk("out_data", 64'(o_data), 64'(q[0].data));
        chk("out_mode", 64'(o_mode), 64'(q[0].mode));
`ifdef GRAY_STEP_CHECK_EN
        chk("out_err", 64'(o_step_err), 64'(q[0].err));
`endif
        if (r) void'(q.pop_front());
      end
    end
    hold_pending = (o_vld === 1'b1) && !r;
    if (v && o_rdy === 1'b1) begin
      e.mode = m;
      e.data = m ? 8'(g2b(64'(d), 8)) : 8'(b2g(64'(d)));
      e.err  = 1'b0;
      if (m) begin
        e.err  = ref_ok && ($countones(d ^ ref_g) > 1);
        ref_g  = d;
        ref_ok = 1'b1;
      end
      q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  // One cycle on the 13-bit instance with a caller-supplied expectation.
  task automatic step13(input logic v, input logic m, input logic [12:0] d, input logic [12:0] e);
    v13 = v; m13 = m; d13 = d; r13 = 1'b1;
    @(negedge clk);
    if (o13_vld === 1'b1) begin
      chk("w13_spurious", 64'(q13.size() != 0), 64'd1);
      if (q13.size() != 0) begin
        chk("w13_data", 64'(o13_data), 64'(q13[0]));
        cap13.push_back(o13_data);
        void'(q13.pop_front());
      end
    end
    if (v && o13_rdy === 1'b1) q13.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int cyc;
    logic [12:0] x;
    rst = 1'b1; i_vld = 1'b0; i_mode = 1'b0; i_data = '0; i_rdy = 1'b1;
    v13 = 1'b0; m13 = 1'b0; d13 = '0; r13 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    step8(1'b0, 1'b0, 8'h00, 1'b1);
    chk("rst_vld", 64'(s_vld), 64'd0);
    chk("rst_data", 64'(s_data), 64'd0);
    chk("rst_mode", 64'(s_mode), 64'd0);
    chk("rst_rdy", 64'(s_rdy), 64'd1);

    // Binary->Gray latency and values
    step8(1'b1, 1'b0, 8'h05, 1'b1);
    chk("b2g_rdy", 64'(s_rdy), 64'd1);
    step8(1'b0, 1'b0, 8'h00, 1'b1);
    chk("lat_early", 64'(s_vld), 64'd0);
    step8(1'b0, 1'b0, 8'h00, 1'b1);
    chk("lat_vld", 64'(s_vld), 64'd1);
    chk("b2g_05", 64'(s_data), 64'h07);
    step8(1'b1, 1'b0, 8'hFF, 1'b1);
    step8(1'b0, 1'b0, 8'h00, 1'b1);
    step8(1'b0, 1'b0, 8'h00, 1'b1);
    chk("b2g_ff", 64'(s_data), 64'h80);

    // Gray->binary back-to-back stream
    step8(1'b1, 1'b1, 8'h07, 1'b1);
    step8(1'b1, 1'b1, 8'h80, 1'b1);
    chk("thru_rdy", 64'(s_rdy), 64'd1);
    step8(1'b1, 1'b1, 8'h00, 1'b1);
    chk("g2b_07", 64'(s_data), 64'h05);
    chk("g2b_mode", 64'(s_mode), 64'd1);
    step8(1'b0, 1'b0, 8'h00, 1'b1);
    chk("g2b_80", 64'(s_data), 64'hFF);
    step8(1'b0, 1'b0, 8'h00, 1'b1);
    chk("g2b_00_vld", 64'(s_vld), 64'd1);
    chk("g2b_00", 64'(s_data), 64'h00);
    step8(1'b0, 1'b0, 8'h00, 1'b1);
    chk("g2b_idle", 64'(s_vld), 64'd0);

    // Reset with two words in flight
    step8(1'b1, 1'b0, 8'h11, 1'b0);
    step8(1'b1, 1'b1, 8'h22, 1'b0);
    rst = 1'b1;
    step8(1'b0, 1'b0, 8'h00, 1'b0);
    q.delete(); hold_pending = 1'b0; ref_ok = 1'b0; ref_g = 8'h00;
    rst = 1'b0;
    step8(1'b0, 1'b0, 8'h00, 1'b1);
    chk("flush_vld", 64'(s_vld), 64'd0);
    chk("flush_data", 64'(s_data), 64'd0);
    chk("flush_rdy", 64'(s_rdy), 64'd1);
    for (int k = 0; k < 4; k++) begin
      step8(1'b0, 1'b0, 8'h00, 1'b1);
      chk("flush_quiet", 64'(s_vld), 64'd0);
    end

`ifdef GRAY_STEP_CHECK_EN
    // First G2B word after reset is never flagged; 03->00 is a two-bit step
    step8(1'b1, 1'b1, 8'h00, 1'b1);
    step8(1'b1, 1'b1, 8'h01, 1'b1);
    step8(1'b1, 1'b1, 8'h03, 1'b1);
    chk("step_00", 64'(s_err), 64'd0);
    step8(1'b1, 1'b1, 8'h00, 1'b1);
    chk("step_01", 64'(s_err), 64'd0);
    step8(1'b0, 1'b0, 8'h00, 1'b1);
    chk("step_03", 64'(s_err), 64'd0);
    step8(1'b0, 1'b0, 8'h00, 1'b1);
    chk("step_00b", 64'(s_err), 64'd1);
`endif

    // Random words, random mode, downstream stalls half the time
    sent = 0;
    cyc  = 0;
    while (sent < 1000 && cyc < 20000) begin
      logic v, m, r;
      logic [7:0] d;
      v = ($urandom_range(0, 3) != 0);
      m = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      r = 1'($urandom_range(0, 1));
      step8(v, m, d, r);
      if (v && s_rdy) sent++;
      cyc++;
    end
    chk("rand_sent", 64'(sent), 64'd1000);
    for (int k = 0; k < 50 && q.size() != 0; k++) step8(1'b0, 1'b0, 8'h00, 1'b1);
    chk("rand_drain", 64'(q.size()), 64'd0);

    // 13-bit, 3-stage: exhaustive Gray->binary
    i_vld = 1'b0;
    for (int g = 0; g < 8192; g++) begin
      x = 13'(g);
      step13(1'b1, 1'b1, x, 13'(g2b(64'(x), 13)));
    end
    for (int k = 0; k < 20 && q13.size() != 0; k++) step13(1'b0, 1'b0, 13'h0, 13'h0);
    chk("w13_g2b_drain", 64'(q13.size()), 64'd0);

    // Round trip: encode every value, then decode the captured codes
    cap13.delete();
    for (int b = 0; b < 8192; b++) begin
      x = 13'(b);
      step13(1'b1, 1'b0, x, 13'(b2g(64'(x))));
    end
    for (int k = 0; k < 20 && q13.size() != 0; k++) step13(1'b0, 1'b0, 13'h0, 13'h0);
    chk("w13_b2g_count", 64'(cap13.size()), 64'd8192);
    rt_src = cap13;
    for (int i = 0; i < rt_src.size(); i++) step13(1'b1, 1'b1, rt_src[i], 13'(i));
    for (int k = 0; k < 20 && q13.size() != 0; k++) step13(1'b0, 1'b0, 13'h0, 13'h0);
    chk("w13_rt_drain", 64'(q13.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
